mskaes_128bits_inv_fsm: RTL and testbench
=========================================

Name: mskaes_128bits_inv_fsm

Overview:
- Control FSM for the masked AES-128 inverse cipher (decryption); drives the same shared-datapath control set as the encryption controller, plus key-schedule direction and first-inverse-round selects.
- Runs a forward key-schedule pass to reach round key K10, applies the initial AddRoundKey, then runs 10 inverse rounds with the key schedule stepping backward.
- Sits beside the masked state/key registers, HPC S-box pipeline and key-schedule unit; purely control, no share data.

Parameters:
- SBOX_LAT, 4, S-box pipeline latency in cycles; each round slot is SBOX_LAT+1 cycles.
- NROUNDS, 10, number of key-schedule iterations and inverse rounds.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- valid_in  in  1  new ciphertext/key shares present on datapath inputs
- key_reuse  in  1  with valid_in: reuse cached K10 (only honoured with KEY_CACHE_EN)
- ready  out  1  FSM in IDLE, accepts valid_in
- plain_valid  out  1  one-cycle pulse: plaintext shares valid in state register
- feed_in  out  1  state/key register input mux selects external shares
- state_reg_enable  out  1  state register load
- state_mux_ark  out  1  state input mux selects the initial AddRoundKey path
- state_mux_firstR  out  1  state input mux selects the first-inverse-round path (no InvMixColumns)
- key_reg_enable  out  1  key register load
- key_cache_store  out  1  copy key register into K10 cache
- key_cache_load  out  1  key register input selects the K10 cache
- SB_valid_in  out  1  S-box input valid
- KS_in_valid  out  1  key-schedule S-box input valid
- KS_rcon_update  out  1  advance rcon one step
- KS_rcon_rst  out  1  rcon to 0x01
- KS_inverse  out  1  0 = forward key step, 1 = inverse key step

Behaviour:
- Async reset (nrst=0): state=IDLE; cnt_fsm=0; cnt_rounds=0; plain_valid=0; cache_valid=0. Takes effect immediately, including mid-operation; any in-flight operation is abandoned, with no plain_valid for it.
- Outputs are combinational from state/counters, except plain_valid, which is registered.
- In IDLE with valid_in=0: ready=1, feed_in=1, state_reg_enable=1, key_reg_enable=1; all other outputs 0.
- cnt_fsm counts 0..SBOX_LAT within a slot and clears at SBOX_LAT. cnt_rounds counts 0..NROUNDS-1 and clears on leaving a phase.
- IDLE, valid_in=1 (fetch cycle):
  - Asserts ready, feed_in, state_reg_enable, key_reg_enable, KS_rcon_rst; clears both counters.
  - If the reuse condition holds, also asserts key_cache_load and the next state is INIT_ARK; otherwise the next state is KEY_FWD.
  - Reuse condition: key_reuse & cache_valid & KEY_CACHE_EN compiled in.
- KEY_FWD, KS_inverse=0, state register untouched:
  - cnt_fsm==0: KS_in_valid=1.
  - cnt_fsm==SBOX_LAT: key_reg_enable=1, KS_rcon_update=1, cnt_rounds++.
  - Leaves after the slot where cnt_rounds==NROUNDS-1. That cycle also asserts key_cache_store and sets cache_valid (macro builds only). Next state: INIT_ARK.
- INIT_ARK (1 cycle): state_mux_ark=1, state_reg_enable=1. Next state: INV_FIRST_R.
- INV_FIRST_R and INV_R, KS_inverse=1:
  - cnt_fsm==0: SB_valid_in=1, KS_in_valid=1.
  - cnt_fsm==SBOX_LAT: state_reg_enable=1, key_reg_enable=1, KS_rcon_update=1, cnt_rounds++.
  - In INV_FIRST_R, state_mux_firstR=1 for the whole slot.
  - INV_FIRST_R runs one slot, then goes to INV_R. INV_R runs NROUNDS-1 slots.
  - At the end of the final INV_R slot, pulse_valid_out=1 and the next state is IDLE.
- plain_valid is registered from pulse_valid_out (high exactly 1 cycle).
- Latency, fetch at cycle T:
  - Full path: plain_valid at T+2+2*NROUNDS*(SBOX_LAT+1). Defaults: T+102.
  - Reuse path: plain_valid at T+2+NROUNDS*(SBOX_LAT+1). Defaults: T+52.
- valid_in is ignored outside IDLE, where ready=0.
- A new fetch is accepted in the IDLE cycle coincident with plain_valid high.
- key_reuse is ignored when valid_in=0.
- If key_reuse=1 and cache_valid=0, the block takes the full path and fills the cache.
- Unused state encodings go to IDLE.

Optional Feature:
- Macro KEY_CACHE_EN.
- Defined: cache_valid register is implemented; key_cache_store/key_cache_load are driven as above; key_reuse is honoured.
- Undefined:
  - key_cache_store and key_cache_load are tied 0; key_reuse port remains but is ignored.
  - Every operation takes the full path; there is no cache_valid register.

Test Plan:
- Reset, hold valid_in=0 for 10 cycles -> ready=1, feed_in=1, state_reg_enable=1, plain_valid=0, KS_inverse=0.
- Single fetch at T, defaults -> exactly 10 KS_in_valid pulses with KS_inverse=0 over T+1..T+50, key_cache_store=1 at T+50, state_mux_ark=1 at T+51, state_mux_firstR=1 over T+52..T+56, 10 SB_valid_in pulses, plain_valid=1 only at T+102.
- With KEY_CACHE_EN: first op full, then a second fetch with key_reuse=1 -> key_cache_load=1 on the fetch cycle, no KEY_FWD phase, plain_valid 52 cycles after fetch.
- key_reuse=1 on the first op after reset -> full path (plain_valid at T+102); without KEY_CACHE_EN, key_reuse=1 always gives T+102.
- Assert nrst low at T+60 for 1 cycle -> immediate IDLE, ready=1, no plain_valid pulse afterwards; the next reuse fetch takes the full path (cache cleared).
- Back-to-back: valid_in held high -> second fetch on the cycle plain_valid=1; the second plain_valid follows exactly 102 cycles later; KS_rcon_rst=1 on each fetch.

Source files
------------

// File: rtl/mskaes_128bits_inv_fsm.sv
// Control FSM for the masked AES-128 inverse cipher: forward key pass to K10,
// initial AddRoundKey, then NROUNDS inverse rounds. Define KEY_CACHE_EN to enable K10 caching.
module mskaes_128bits_inv_fsm #(
  parameter int SBOX_LAT = 4,
  parameter int NROUNDS  = 10
) (
  input  logic clk,
  input  logic nrst,
  input  logic valid_in,
  input  logic key_reuse,
  output logic ready,
  output logic plain_valid,
  output logic feed_in,
  output logic state_reg_enable,
  output logic state_mux_ark,
  output logic state_mux_firstR,
  output logic key_reg_enable,
  output logic key_cache_store,
  output logic key_cache_load,
  output logic SB_valid_in,
  output logic KS_in_valid,
  output logic KS_rcon_update,
  output logic KS_rcon_rst,
  output logic KS_inverse
);

  localparam int CFW = (SBOX_LAT > 0) ? $clog2(SBOX_LAT + 1) : 1;
  localparam int CRW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;
  localparam logic [CFW-1:0] SLOT_LAST  = CFW'(SBOX_LAT);
  localparam logic [CRW-1:0] ROUND_LAST = CRW'(NROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    KEY_FWD     = 3'd1,
    INIT_ARK    = 3'd2,
    INV_FIRST_R = 3'd3,
    INV_R       = 3'd4
  } state_t;

  state_t         state, next_state;
  logic [CFW-1:0] cnt_fsm;
  logic [CRW-1:0] cnt_rounds;
  logic           slot_end;
  logic           last_round;
  logic           reuse;
  logic           pulse_valid_out;

  assign slot_end   = (cnt_fsm == SLOT_LAST);
  assign last_round = (cnt_rounds == ROUND_LAST);

`ifdef KEY_CACHE_EN
  localparam logic CACHE_IMPL = 1'b1;
  logic cache_valid;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      cache_valid <= 1'b0;
    else if (key_cache_store)
      cache_valid <= 1'b1;
  end

  assign reuse = key_reuse & cache_valid;
`else
  localparam logic CACHE_IMPL = 1'b0;
  logic unused_key_reuse;
  assign unused_key_reuse = key_reuse;
  assign reuse = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Slot counter wraps every SBOX_LAT+1 cycles; the round counter spans both inverse states.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_fsm    <= '0;
      cnt_rounds <= '0;
    end else begin
      case (state)
        KEY_FWD, INV_FIRST_R, INV_R: begin
          cnt_fsm <= slot_end ? '0 : cnt_fsm + 1'b1;
          if (slot_end)
            cnt_rounds <= last_round ? '0 : cnt_rounds + 1'b1;
        end
        default: begin
          cnt_fsm    <= '0;
          cnt_rounds <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      plain_valid <= 1'b0;
    else
      plain_valid <= pulse_valid_out;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (valid_in) next_state = reuse ? INIT_ARK : KEY_FWD;
      KEY_FWD:     if (slot_end && last_round) next_state = INIT_ARK;
      INIT_ARK:    next_state = INV_FIRST_R;
      INV_FIRST_R: if (slot_end) next_state = INV_R;
      INV_R:       if (slot_end && last_round) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_comb begin
    ready            = 1'b0;
    feed_in          = 1'b0;
    state_reg_enable = 1'b0;
    state_mux_ark    = 1'b0;
    state_mux_firstR = 1'b0;
    key_reg_enable   = 1'b0;
    key_cache_store  = 1'b0;
    key_cache_load   = 1'b0;
    SB_valid_in      = 1'b0;
    KS_in_valid      = 1'b0;
    KS_rcon_update   = 1'b0;
    KS_rcon_rst      = 1'b0;
    KS_inverse       = 1'b0;
    pulse_valid_out  = 1'b0;
    case (state)
      IDLE: begin
        ready            = 1'b1;
        feed_in          = 1'b1;
        state_reg_enable = 1'b1;
        key_reg_enable   = 1'b1;
        if (valid_in) begin
          KS_rcon_rst    = 1'b1;
          key_cache_load = reuse;
        end
      end
      KEY_FWD: begin
        KS_in_valid = (cnt_fsm == '0);
        if (slot_end) begin
          key_reg_enable  = 1'b1;
          KS_rcon_update  = 1'b1;
          key_cache_store = CACHE_IMPL & last_round;
        end
      end
      INIT_ARK: begin
        state_mux_ark    = 1'b1;
        state_reg_enable = 1'b1;
      end
      INV_FIRST_R, INV_R: begin
        KS_inverse       = 1'b1;
        state_mux_firstR = (state == INV_FIRST_R);
        SB_valid_in      = (cnt_fsm == '0);
        KS_in_valid      = (cnt_fsm == '0);
        if (slot_end) begin
          state_reg_enable = 1'b1;
          key_reg_enable   = 1'b1;
          KS_rcon_update   = 1'b1;
          pulse_valid_out  = (state == INV_R) & last_round;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mskaes_128bits_inv_fsm.sv
// Directed bench for mskaes_128bits_inv_fsm with a plain_valid timing scoreboard.
// Compile with KEY_CACHE_EN to exercise the K10 cache expectations.
module tb_mskaes_128bits_inv_fsm;

`ifdef KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst, valid_in, key_reuse;
  logic ready, plain_valid, feed_in, state_reg_enable, state_mux_ark, state_mux_firstR;
  logic key_reg_enable, key_cache_store, key_cache_load, SB_valid_in, KS_in_valid;
  logic KS_rcon_update, KS_rcon_rst, KS_inverse;

  mskaes_128bits_inv_fsm dut (
    .clk(clk), .nrst(nrst), .valid_in(valid_in), .key_reuse(key_reuse),
    .ready(ready), .plain_valid(plain_valid), .feed_in(feed_in),
    .state_reg_enable(state_reg_enable), .state_mux_ark(state_mux_ark),
    .state_mux_firstR(state_mux_firstR), .key_reg_enable(key_reg_enable),
    .key_cache_store(key_cache_store), .key_cache_load(key_cache_load),
    .SB_valid_in(SB_valid_in), .KS_in_valid(KS_in_valid),
    .KS_rcon_update(KS_rcon_update), .KS_rcon_rst(KS_rcon_rst), .KS_inverse(KS_inverse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  int exp_q[$];
  bit tb_cache = 1'b0;
  bit fill_pending = 1'b0;
  int fill_at = 0;

  int ks_fwd_cnt, ks_fwd_first, ks_fwd_last, store_cnt, store_at, ark_cnt, ark_at;
  int firstr_cnt, firstr_first, firstr_last, sb_cnt, pv_cnt, pv_at;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic kr);
    @(negedge clk);
    valid_in  = v;
    key_reuse = kr;
    #1;
  endtask

  task automatic clearTrace();
    ks_fwd_cnt = 0; ks_fwd_first = -1; ks_fwd_last = -1; store_cnt = 0; store_at = -1;
    ark_cnt = 0; ark_at = -1; firstr_cnt = 0; firstr_first = -1; firstr_last = -1;
    sb_cnt = 0; pv_cnt = 0; pv_at = -1;
  endtask

  task automatic traceCycle();
    if (KS_in_valid && !KS_inverse) begin
      if (ks_fwd_cnt == 0) ks_fwd_first = cyc;
      ks_fwd_last = cyc;
      ks_fwd_cnt++;
    end
    if (key_cache_store) begin store_cnt++; store_at = cyc; end
    if (state_mux_ark) begin ark_cnt++; ark_at = cyc; end
    if (state_mux_firstR) begin
      if (firstr_cnt == 0) firstr_first = cyc;
      firstr_last = cyc;
      firstr_cnt++;
    end
    if (SB_valid_in) sb_cnt++;
    if (plain_valid) begin pv_cnt++; pv_at = cyc; end
  endtask

  // Scoreboard: each accepted fetch pushes the cycle its plain_valid is due on.
  always @(negedge clk) begin
    bit reuse_exp;
    #2;
    if (nrst === 1'b1) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        checkOutput("plain_valid missing", 32'(cyc), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (plain_valid === 1'b1) begin
        if (exp_q.size() == 0)
          checkOutput("unexpected plain_valid", 32'd1, 32'd0);
        else
          checkOutput("plain_valid cycle", 32'(cyc), 32'(exp_q.pop_front()));
      end
      if (ready === 1'b1 && valid_in === 1'b1) begin
        reuse_exp = CACHE && key_reuse && tb_cache;
        checkOutput("fetch KS_rcon_rst", 32'(KS_rcon_rst), 32'd1);
        checkOutput("fetch key_cache_load", 32'(key_cache_load), 32'(reuse_exp));
        exp_q.push_back(cyc + (reuse_exp ? 52 : 102));
        if (!reuse_exp) begin
          fill_pending = 1'b1;
          fill_at = cyc + 50;
        end
      end
      if (fill_pending && cyc == fill_at) begin
        fill_pending = 1'b0;
        tb_cache = CACHE;
      end
    end
  end

  initial begin
    int t;
    int fetches, f1, f2, pv_at_f2, ready_busy;
    nrst = 1'b0; valid_in = 1'b0; key_reuse = 1'b0;
    clearTrace();

    // Reset and idle behaviour
    applyStimulus(0, 0);
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset plain_valid", 32'(plain_valid), 32'd0);
    @(negedge clk); nrst = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(0, 0);
    checkOutput("idle ready", 32'(ready), 32'd1);
    checkOutput("idle feed_in", 32'(feed_in), 32'd1);
    checkOutput("idle state_reg_enable", 32'(state_reg_enable), 32'd1);
    checkOutput("idle key_reg_enable", 32'(key_reg_enable), 32'd1);
    checkOutput("idle plain_valid", 32'(plain_valid), 32'd0);
    checkOutput("idle KS_inverse", 32'(KS_inverse), 32'd0);
    checkOutput("idle KS_rcon_rst", 32'(KS_rcon_rst), 32'd0);
    checkOutput("idle SB_valid_in", 32'(SB_valid_in), 32'd0);

    // Single full-path operation
    clearTrace();
    applyStimulus(1, 0);
    t = cyc;
    checkOutput("fetch ready", 32'(ready), 32'd1);
    traceCycle();
    for (int i = 0; i < 104; i++) begin applyStimulus(0, 0); traceCycle(); end
    checkOutput("fwd KS pulses", 32'(ks_fwd_cnt), 32'd10);
    checkOutput("fwd KS first", 32'(ks_fwd_first), 32'(t + 1));
    checkOutput("fwd KS last", 32'(ks_fwd_last), 32'(t + 46));
    checkOutput("cache store count", 32'(store_cnt), 32'(CACHE ? 1 : 0));
    if (CACHE) checkOutput("cache store cycle", 32'(store_at), 32'(t + 50));
    checkOutput("ark count", 32'(ark_cnt), 32'd1);
    checkOutput("ark cycle", 32'(ark_at), 32'(t + 51));
    checkOutput("firstR count", 32'(firstr_cnt), 32'd5);
    checkOutput("firstR first", 32'(firstr_first), 32'(t + 52));
    checkOutput("firstR last", 32'(firstr_last), 32'(t + 56));
    checkOutput("SB pulses", 32'(sb_cnt), 32'd10);
    checkOutput("plain_valid count", 32'(pv_cnt), 32'd1);
    checkOutput("plain_valid at", 32'(pv_at), 32'(t + 102));

    // Key reuse after a completed op
    clearTrace();
    applyStimulus(1, 1);
    t = cyc;
    checkOutput("reuse key_cache_load", 32'(key_cache_load), 32'(CACHE));
    traceCycle();
    for (int i = 0; i < 104; i++) begin applyStimulus(0, 0); traceCycle(); end
    checkOutput("reuse fwd KS pulses", 32'(ks_fwd_cnt), 32'(CACHE ? 0 : 10));
    checkOutput("reuse ark cycle", 32'(ark_at), 32'(t + (CACHE ? 1 : 51)));
    checkOutput("reuse plain_valid at", 32'(pv_at), 32'(t + (CACHE ? 52 : 102)));

    // Reset mid-operation abandons it and clears the cache
    applyStimulus(1, 0);
    t = cyc;
    while (cyc < t + 60) applyStimulus(0, 0);
    @(negedge clk);
    nrst = 1'b0;
    exp_q.delete(); tb_cache = 1'b0; fill_pending = 1'b0;
    #1;
    checkOutput("midreset ready", 32'(ready), 32'd1);
    checkOutput("midreset KS_inverse", 32'(KS_inverse), 32'd0);
    checkOutput("midreset SB_valid_in", 32'(SB_valid_in), 32'd0);
    @(negedge clk); nrst = 1'b1;
    clearTrace();
    for (int i = 0; i < 110; i++) begin applyStimulus(0, 0); traceCycle(); end
    checkOutput("no plain_valid after reset", 32'(pv_cnt), 32'd0);
    clearTrace();
    applyStimulus(1, 1);
    t = cyc;
    checkOutput("postreset key_cache_load", 32'(key_cache_load), 32'd0);
    traceCycle();
    for (int i = 0; i < 104; i++) begin applyStimulus(0, 0); traceCycle(); end
    checkOutput("postreset fwd KS pulses", 32'(ks_fwd_cnt), 32'd10);
    checkOutput("postreset plain_valid at", 32'(pv_at), 32'(t + 102));

    // Back-to-back with valid_in held high
    clearTrace();
    fetches = 0; f1 = -1; f2 = -1; pv_at_f2 = 0; ready_busy = -1;
    for (int i = 0; i < 215; i++) begin
      applyStimulus(fetches < 2, 0);
      traceCycle();
      if (ready && valid_in) begin
        fetches++;
        if (fetches == 1) f1 = cyc;
        else begin f2 = cyc; pv_at_f2 = int'(plain_valid); end
      end
      if (fetches == 1 && cyc == f1 + 30) ready_busy = int'(ready);
    end
    checkOutput("b2b fetch count", 32'(fetches), 32'd2);
    checkOutput("b2b fetch spacing", 32'(f2 - f1), 32'd102);
    checkOutput("b2b plain_valid on fetch", 32'(pv_at_f2), 32'd1);
    checkOutput("b2b busy ready", 32'(ready_busy), 32'd0);
    checkOutput("b2b second plain_valid", 32'(pv_at), 32'(f2 + 102));

    for (int i = 0; i < 300 && exp_q.size() > 0; i++) applyStimulus(0, 0);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
